// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake movement engine (head/direction encoding, FSM states).
package snake_pkg;

  localparam int COORD_W = 5;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } pos_t;

  function automatic pos_t unpack_pos(input logic [2*COORD_W-1:0] p);
    return pos_t'(p);
  endfunction

  function automatic logic [2*COORD_W-1:0] pack_pos(input logic [COORD_W-1:0] y,
                                                     input logic [COORD_W-1:0] x);
    return {y, x};
  endfunction

  // Direction encoding places opposites two apart, so flipping bit 1 reverses.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/snake_next_pos.sv
// Combinational next-head calculator. With SNAKE_WRAP_EN the board is a torus;
// without it, leaving the board raises edge_hit.
module snake_next_pos
  import snake_pkg::*;
(
  input  logic [2*COORD_W-1:0] head,
  input  logic [1:0]           dir,
  output logic [2*COORD_W-1:0] next_head,
  output logic                 edge_hit
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  pos_t cur, nxt;
  logic off_board;

  always_comb begin
    cur       = unpack_pos(head);
    nxt       = cur;
    off_board = 1'b0;
    case (dir)
      DIR_UP:    begin nxt.y = cur.y - ONE; off_board = (cur.y == '0); end
      DIR_RIGHT: begin nxt.x = cur.x + ONE; off_board = (cur.x == '1); end
      DIR_DOWN:  begin nxt.y = cur.y + ONE; off_board = (cur.y == '1); end
      DIR_LEFT:  begin nxt.x = cur.x - ONE; off_board = (cur.x == '0); end
    endcase
    next_head = pack_pos(nxt.y, nxt.x);
  end

`ifdef SNAKE_WRAP_EN
  logic unused_off;
  assign unused_off = off_board;
  assign edge_hit   = 1'b0;
`else
  assign edge_hit   = off_board;
`endif

endmodule

// File: rtl/snake_mover.sv
// Per-snake movement engine: FSM, body shift register, length counter and
// self-collision compare. Edge behaviour selected by SNAKE_WRAP_EN.
module snake_mover
  import snake_pkg::*;
#(
  parameter int                 MAX_LEN         = 16,
  parameter int                 NUM_LEN         = 2*COORD_W,
  parameter int                 MAX_LEN_BIT_LEN = 4,
  parameter logic [NUM_LEN-1:0] INIT_HEAD       = {5'd16, 5'd16}
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       step,
  input  logic [1:0]                 dir_in,
  input  logic [MAX_LEN_BIT_LEN-1:0] score,
  output logic [NUM_LEN-1:0]         snake_head,
  output logic [MAX_LEN*NUM_LEN-1:0] body,
  output logic [MAX_LEN_BIT_LEN:0]   length,
  output logic                       moved,
  output logic                       dead
);

  localparam int             LW        = MAX_LEN_BIT_LEN + 1;
  localparam logic [LW-1:0]  MAX_LEN_L = LW'(MAX_LEN);

  state_e state_q, state_d;
  logic [1:0]                       dir_q, dir_eff;
  logic [MAX_LEN-1:0][NUM_LEN-1:0]  body_q;
  logic [LW-1:0]                    len_q, score_p1, target;
  logic [NUM_LEN-1:0]               next_head;
  logic [MAX_LEN-1:0]               hit;
  logic moved_q, dead_q, grow, edge_hit, collide, init, adv;

  assign dir_eff = (dir_in == reverse_dir(dir_q)) ? dir_q : dir_in;

  snake_next_pos u_next_pos (
    .head      (body_q[0]),
    .dir       (dir_eff),
    .next_head (next_head),
    .edge_hit  (edge_hit)
  );

  assign score_p1 = {1'b0, score} + LW'(1);
  assign target   = (score_p1 > MAX_LEN_L) ? MAX_LEN_L : score_p1;
  assign grow     = (len_q < target);

  // Tail is exempt when not growing: it moves out of the way on this same step.
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_hit
    assign hit[g] = (body_q[g] == next_head) && (LW'(g) < len_q) &&
                    (grow || (LW'(g) != len_q - LW'(1)));
  end

  assign collide = (|hit) | edge_hit;

  always_comb begin
    state_d = state_q;
    init    = 1'b0;
    adv     = 1'b0;
    if (start) begin
      init    = 1'b1;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: if (step) begin
          if (collide) state_d = ST_DEAD;
          else         adv     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dead_q  <= (state_d == ST_DEAD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      body_q  <= {MAX_LEN{INIT_HEAD}};
      len_q   <= LW'(1);
      dir_q   <= DIR_RIGHT;
      moved_q <= 1'b0;
    end else begin
      moved_q <= adv;
      if (adv) begin
        body_q <= {body_q[MAX_LEN-2:0], next_head};
        dir_q  <= dir_eff;
        if (grow) len_q <= len_q + LW'(1);
      end
    end
  end

  assign snake_head = body_q[0];
  assign body       = body_q;
  assign length     = len_q;
  assign moved      = moved_q;
  assign dead       = dead_q;

endmodule
